// File: rtl/i2s_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : i2s_deserializer
// Brief   : Oversampled ADC-side I2S / left-justified capture into L/R pairs.
// Revision: 1.0
// ============================================================================
module i2s_deserializer #(
    parameter int DATA_WIDTH = 16,
    parameter int LR_DELAY   = 0,
    parameter bit LEFT_LEVEL = 1'b1
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  BCLK,
    input  logic                  ADCLRCK,
    input  logic                  ADCDAT,
    output logic [DATA_WIDTH-1:0] leftSample,
    output logic [DATA_WIDTH-1:0] rightSample,
    output logic                  sampleValid,
    output logic                  frameErr
);

    localparam int c_WORD_END = DATA_WIDTH + LR_DELAY;
    localparam int c_CNT_W    = $clog2(c_WORD_END + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_WORD_END - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_WORD_END);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_SYNC  = 2'd0;
    localparam logic [1:0] c_LEFT  = 2'd1;
    localparam logic [1:0] c_RIGHT = 2'd2;

    logic r_bclk_meta, r_bclk_sync, r_bclk_hist;
    logic r_lrck_meta, r_lrck_sync, r_lrck_hist;
    logic r_dat_meta,  r_dat_sync;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_word_done;
    logic [DATA_WIDTH-1:0] r_hold_left;
    logic [DATA_WIDTH-1:0] r_hold_right;
    logic                  r_left_ok;
    logic                  r_pair_pend;

    logic                  w_bclk_rise;
    logic                  w_lrck_edge;
    logic                  w_to_left;
    logic [1:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    w_cnt_base;
    logic [DATA_WIDTH-1:0] w_shift_base;
    logic                  w_done_base;
    logic                  w_err;
    logic                  w_past_delay;
    logic                  w_take_bit;
    logic                  w_capture;
    logic                  w_complete;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_done_nxt;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_bclk_meta <= 1'b0;
            r_bclk_sync <= 1'b0;
            r_bclk_hist <= 1'b0;
            r_lrck_meta <= 1'b0;
            r_lrck_sync <= 1'b0;
            r_lrck_hist <= 1'b0;
            r_dat_meta  <= 1'b0;
            r_dat_sync  <= 1'b0;
        end else begin
            r_bclk_meta <= BCLK;
            r_bclk_sync <= r_bclk_meta;
            r_bclk_hist <= r_bclk_sync;
            r_lrck_meta <= ADCLRCK;
            r_lrck_sync <= r_lrck_meta;
            r_lrck_hist <= r_lrck_sync;
            r_dat_meta  <= ADCDAT;
            r_dat_sync  <= r_dat_meta;
        end
    end

    assign w_bclk_rise = r_bclk_sync & ~r_bclk_hist;
    assign w_lrck_edge = r_lrck_sync ^ r_lrck_hist;
    assign w_to_left   = (r_lrck_sync == LEFT_LEVEL);

    // Frame-clock edge is resolved first so a coincident BCLK rise lands as bit 0.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_base   = r_bit_cnt;
        w_shift_base = r_shift;
        w_done_base  = r_word_done;
        w_err        = 1'b0;
        if (w_lrck_edge) begin
            if ((r_state != c_SYNC) && !r_word_done) begin
                w_err = 1'b1;
            end
            if ((r_state != c_SYNC) || w_to_left) begin
                w_state_nxt  = w_to_left ? c_LEFT : c_RIGHT;
                w_cnt_base   = '0;
                w_shift_base = '0;
                w_done_base  = 1'b0;
            end
        end
    end

    generate
        if (LR_DELAY > 0) begin : g_delay
            assign w_past_delay = (w_cnt_base >= c_CNT_W'(LR_DELAY));
        end else begin : g_no_delay
            assign w_past_delay = 1'b1;
        end
    endgenerate

    assign w_take_bit  = w_bclk_rise && (w_state_nxt != c_SYNC);
    assign w_capture   = w_take_bit && w_past_delay && !w_done_base;
    assign w_complete  = w_capture && (w_cnt_base == c_CNT_LAST);
    assign w_shift_nxt = w_capture ? {w_shift_base[DATA_WIDTH-2:0], r_dat_sync} : w_shift_base;
    assign w_cnt_nxt   = (w_take_bit && (w_cnt_base != c_CNT_SAT)) ? (w_cnt_base + c_CNT_ONE)
                                                                   : w_cnt_base;
    assign w_done_nxt  = w_done_base || w_complete;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state      <= c_SYNC;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_word_done  <= 1'b0;
            r_hold_left  <= '0;
            r_hold_right <= '0;
            r_left_ok    <= 1'b0;
            r_pair_pend  <= 1'b0;
            leftSample   <= '0;
            rightSample  <= '0;
            sampleValid  <= 1'b0;
            frameErr     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_word_done <= w_done_nxt;
            frameErr    <= w_err;
            sampleValid <= r_pair_pend;
            r_pair_pend <= 1'b0;

            if (r_pair_pend) begin
                leftSample  <= r_hold_left;
                rightSample <= r_hold_right;
            end

            // A right word only becomes a pair when this frame's left word completed.
            if (w_complete) begin
                if (w_state_nxt == c_LEFT) begin
                    r_hold_left <= w_shift_nxt;
                end else begin
                    r_hold_right <= w_shift_nxt;
                    r_pair_pend  <= r_left_ok;
                end
            end

            if (w_complete && (w_state_nxt == c_LEFT)) begin
                r_left_ok <= 1'b1;
            end else if (r_pair_pend || (w_err && (r_state == c_LEFT))) begin
                r_left_ok <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_deserializer.sv
`default_nettype none
// Bench for i2s_deserializer: a left-justified instance (bus 0) and an I2S
// instance with active-low left level (bus 1), driven from an async BCLK.
module tb_i2s_deserializer;

    localparam bit LL0 = 1'b1;
    localparam bit LL1 = 1'b0;
    localparam int D0  = 0;
    localparam int D1  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  bclk, lrck, dat;
    logic [15:0] left0, right0, left1, right1;
    logic        sv0, sv1, fe0, fe1;

    int checks = 0;
    int errors = 0;
    int obs_err [2] = '{0, 0};
    int exp_err [2];
    int rd [2];
    logic [31:0] obs_q0[$], obs_q1[$], exp_q0[$], exp_q1[$];

    bit          m_synced   [2];
    bit          m_left_bad [2];
    int          m_prev_rn  [2];
    logic [31:0] m_last     [2];

    always #5 clk = ~clk;

    i2s_deserializer #(.DATA_WIDTH(16), .LR_DELAY(D0), .LEFT_LEVEL(LL0)) dut0 (
        .CLOCK_50(clk), .RESET(rst), .BCLK(bclk[0]), .ADCLRCK(lrck[0]), .ADCDAT(dat[0]),
        .leftSample(left0), .rightSample(right0), .sampleValid(sv0), .frameErr(fe0)
    );

    i2s_deserializer #(.DATA_WIDTH(16), .LR_DELAY(D1), .LEFT_LEVEL(LL1)) dut1 (
        .CLOCK_50(clk), .RESET(rst), .BCLK(bclk[1]), .ADCLRCK(lrck[1]), .ADCDAT(dat[1]),
        .leftSample(left1), .rightSample(right1), .sampleValid(sv1), .frameErr(fe1)
    );

    always @(negedge clk) begin
        if (sv0) obs_q0.push_back({left0, right0});
        if (sv1) obs_q1.push_back({left1, right1});
        if (fe0) obs_err[0] = obs_err[0] + 1;
        if (fe1) obs_err[1] = obs_err[1] + 1;
    end

    function automatic int d_of(input int b);
        return (b == 0) ? D0 : D1;
    endfunction

    function automatic logic ll_of(input int b);
        return (b == 0) ? LL0 : LL1;
    endfunction

    function automatic logic [63:0] mk_slot(input logic [15:0] w, input int d,
                                            input logic garb, input logic pad);
        logic [63:0] s;
        s = {64{pad}};
        for (int i = 0; i < d; i++) s[63-i] = garb;
        for (int j = 0; j < 16; j++) s[63-d-j] = w[15-j];
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input int b, input string tag);
        int n_obs, n_exp;
        n_obs = (b == 0) ? obs_q0.size() : obs_q1.size();
        n_exp = (b == 0) ? exp_q0.size() : exp_q1.size();
        check({tag, " pairs"}, 32'(n_obs), 32'(n_exp));
        for (int i = rd[b]; i < n_obs && i < n_exp; i++)
            check({tag, " data"}, (b == 0) ? obs_q0[i] : obs_q1[i],
                                  (b == 0) ? exp_q0[i] : exp_q1[i]);
        rd[b] = (n_obs > n_exp) ? n_obs : n_exp;
        check({tag, " errs"}, 32'(obs_err[b]), 32'(exp_err[b]));
        check({tag, " hold"}, (b == 0) ? {left0, right0} : {left1, right1}, m_last[b]);
    endtask

    // Frame clock and data change together with the BCLK falling edge.
    task automatic drive_slot(input int b, input logic lvl, input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            lrck[b] = lvl;
            dat[b]  = bits[63-i];
            #40 bclk[b] = 1'b1;
            #40 bclk[b] = 1'b0;
        end
    endtask

    task automatic send_frame(input int b, input logic [15:0] lw, input logic [15:0] rw,
                              input int ln, input int rn, input logic garb, input logic pad);
        int need;
        bit lok;
        need = 16 + d_of(b);
        if (m_synced[b] && m_prev_rn[b] < need) exp_err[b]++;
        m_synced[b]   = 1'b1;
        m_left_bad[b] = 1'b0;
        drive_slot(b, ll_of(b), mk_slot(lw, d_of(b), garb, pad), ln);
        if (m_synced[b] && (ln < need || m_left_bad[b])) exp_err[b]++;
        lok = m_synced[b] && (ln >= need) && !m_left_bad[b];
        drive_slot(b, ~ll_of(b), mk_slot(rw, d_of(b), garb, pad), rn);
        if (m_synced[b] && lok && rn >= need) begin
            if (b == 0) exp_q0.push_back({lw, rw});
            else        exp_q1.push_back({lw, rw});
            m_last[b] = {lw, rw};
        end
        m_prev_rn[b] = rn;
    endtask

    task automatic reset_assert();
        rst = 1'b1;
        for (int b = 0; b < 2; b++) begin
            m_synced[b] = 1'b0;
            m_last[b]   = '0;
        end
    endtask

    // Synchronizers restart from 0, so a high left level looks like a fresh left entry.
    task automatic reset_release();
        rst = 1'b0;
        for (int b = 0; b < 2; b++) begin
            if (lrck[b] == 1'b1 && ll_of(b) == 1'b1) begin
                m_synced[b]   = 1'b1;
                m_left_bad[b] = 1'b1;
            end
        end
    endtask

    initial begin
        bclk = 2'b00;
        dat  = 2'b00;
        lrck[0] = ~LL0;
        lrck[1] = ~LL1;
        for (int b = 0; b < 2; b++) begin
            exp_err[b] = 0; rd[b] = 0; m_synced[b] = 1'b0;
            m_left_bad[b] = 1'b0; m_prev_rn[b] = 99; m_last[b] = '0;
        end
        reset_assert();
        #53;
        check("reset left0",  32'(left0),  32'h0);
        check("reset right0", 32'(right0), 32'h0);
        check("reset sv0",    32'(sv0),    32'h0);
        check("reset fe0",    32'(fe0),    32'h0);
        check("reset left1",  32'(left1),  32'h0);
        check("reset right1", 32'(right1), 32'h0);
        check("reset sv1",    32'(sv1),    32'h0);
        check("reset fe1",    32'(fe1),    32'h0);
        reset_release();
        #100;

        send_frame(0, 16'hA5C3, 16'h1234, 16, 16, 1'b0, 1'b0);
        #200 check_bus(0, "lj32");
        send_frame(0, 16'hA5C3, 16'h1234, 32, 32, 1'b0, 1'b1);
        #200 check_bus(0, "lj64_pad");
        send_frame(1, 16'h8001, 16'h7FFE, 32, 32, 1'b1, 1'b0);
        #200 check_bus(1, "i2s");
        send_frame(0, 16'hDEAD, 16'hBEEF, 10, 16, 1'b0, 1'b0);
        #200 check_bus(0, "short_left");
        send_frame(0, 16'h0F0F, 16'hF0F0, 16, 24, 1'b0, 1'b1);
        #200 check_bus(0, "recover");

        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 2; b++) begin
                send_frame(b, 16'($urandom), 16'($urandom),
                           16 + d_of(b) + int'($urandom_range(0, 15)),
                           16 + d_of(b) + int'($urandom_range(0, 15)),
                           1'($urandom), 1'($urandom));
            end
        end
        #200 check_bus(0, "rand0");
        check_bus(1, "rand1");

        // Reset released mid right word: nothing until a whole frame follows.
        reset_assert();
        #31 check("rst_mid_right out0", {left0, right0}, 32'h0);
        fork
            drive_slot(0, ~LL0, mk_slot(16'h5555, D0, 1'b0, 1'b0), 16);
            begin
                #250 reset_release();
            end
        join
        send_frame(0, 16'h1357, 16'h2468, 16, 16, 1'b0, 1'b0);
        #200 check_bus(0, "rst_mid_right");

        // Reset pulse during the 8th left bit of a running frame.
        fork
            send_frame(0, 16'hCAFE, 16'hF00D, 16, 16, 1'b0, 1'b0);
            begin
                #610 reset_assert();
                #1 check("rst_in_left out0", {left0, right0}, 32'h0);
                check("rst_in_left sv0", 32'(sv0), 32'h0);
                #24 reset_release();
            end
        join
        #200 check_bus(0, "rst_in_left");
        send_frame(0, 16'h0123, 16'h4567, 16, 16, 1'b0, 1'b1);
        #200 check_bus(0, "resume");
        check_bus(1, "bus1_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
